// File: rtl/regfile_wb_sink.sv
// Integer register file at the end of the writeback path.
//
// Purpose:
//   - Commits WB-stage writes (wb_rd / wb_data / wb_we) to architectural state. x0 is hardwired
//     to zero.
//   - Serves two ID-stage read ports with a combinational, same-cycle write-to-read bypass.
//   - Tracks in-flight writes per register with a small saturating counter. ID registers each
//     issued destination and WB retires it. stall is raised when a source operand is still
//     pending, or when the destination counter has no headroom left.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous, active-high reset
//   wb_rd          writeback destination register
//   wb_data        writeback data
//   wb_we          writeback enable
//   rs1_addr       read port 1 address
//   rs2_addr       read port 2 address
//   rs1_data       read port 1 data (combinational)
//   rs2_data       read port 2 data (combinational)
//   issue_valid    ID presents an instruction this cycle
//   issue_rd       destination of the presented instruction
//   issue_wr       presented instruction writes issue_rd
//   issue_use_rs1  presented instruction reads rs1_addr
//   issue_use_rs2  presented instruction reads rs2_addr
//   stall          issue refused this cycle (combinational)
module regfile_wb_sink #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            wb_we,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            issue_wr,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  output logic            stall
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Architectural state and pending-write counters.
  logic [XLEN-1:0]  regs_q [NREG];
  logic [CNT_W-1:0] cnt_q  [NREG];

  logic            retire;
  logic            accept;
  logic            haz1;
  logic            haz2;
  logic            sat;
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;

  // A retire is any real WB write. Writes to x0 are dropped and leave every counter alone.
  assign retire = wb_we && (wb_rd != 5'd0);

  // Read ports: x0 reads zero, and a same-cycle WB write to the addressed register is forwarded.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      if (wb_we && (wb_rd == rs1_addr)) begin
        rs1_data = wb_data;
      end else begin
        rs1_data = regs_q[rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      if (wb_we && (wb_rd == rs2_addr)) begin
        rs2_data = wb_data;
      end else begin
        rs2_data = regs_q[rs2_addr];
      end
    end
  end

  // Hazard detection. A source whose only outstanding write retires this cycle is not a hazard,
  // because the bypass delivers the value. A counter above one still has older writers in flight.
  always_comb begin
    haz1 = issue_use_rs1 && (rs1_addr != 5'd0) && (cnt_q[rs1_addr] != '0);
    if ((cnt_q[rs1_addr] == CntOne) && retire && (wb_rd == rs1_addr)) begin
      haz1 = 1'b0;
    end

    haz2 = issue_use_rs2 && (rs2_addr != 5'd0) && (cnt_q[rs2_addr] != '0);
    if ((cnt_q[rs2_addr] == CntOne) && retire && (wb_rd == rs2_addr)) begin
      haz2 = 1'b0;
    end

    // A full counter can still accept a new issue when a retire frees a slot this same cycle.
    sat = issue_wr && (issue_rd != 5'd0) && (cnt_q[issue_rd] == CntMax) &&
          !(retire && (wb_rd == issue_rd));
  end

  assign stall  = issue_valid && (haz1 || haz2 || sat);
  assign accept = issue_valid && !stall && issue_wr && (issue_rd != 5'd0);

  // Per-register increment/decrement requests.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NREG; i++) begin
      inc[i] = accept && (issue_rd == 5'(i));
      dec[i] = retire && (wb_rd == 5'(i));
    end
  end

  // Counters: accept and retire on the same register cancel. Decrement floors at zero; increment
  // at max cannot occur because sat blocks it unless a same-register retire cancels it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt_q[i] <= cnt_q[i] + CntOne;
        end else if (dec[i] && !inc[i] && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - CntOne;
        end
      end
    end
  end

  // Data storage. Entry 0 is never written because retire excludes wb_rd == 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (dec[i]) begin
          regs_q[i] <= wb_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sink.sv
module tb_regfile_wb_sink;

  logic        clk;
  logic        reset;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_wr;
  logic        issue_use_rs1;
  logic        issue_use_rs2;
  logic        stall;

  regfile_wb_sink #(
    .NREG (32),
    .XLEN (32),
    .CNT_W(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_we        (wb_we),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_wr     (issue_wr),
    .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2),
    .stall        (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: register contents and number of issued-but-unretired writes.
  logic [31:0] mreg [32];
  int          mcnt [32];
  localparam int MaxPending = 3;

  typedef struct {
    bit          we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  a1;
    logic [4:0]  a2;
    bit          iv;
    logic [4:0]  ird;
    bit          iwr;
    bit          u1;
    bit          u2;
    logic [31:0] e1;
    logic [31:0] e2;
    bit          est;
  } vec_t;

  vec_t vecs[$];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mreg[i] = '0;
      mcnt[i] = 0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_we && wb_rd == a) return wb_data;
    return mreg[a];
  endfunction

  // Applies the current inputs for one cycle: checks outputs at the falling edge, then advances
  // the reference model past the rising edge. Table mode compares against fixed constants.
  task automatic run_cycle(input string name, input bit use_tab, input logic [31:0] t1,
                           input logic [31:0] t2, input bit tst);
    logic [31:0] e1, e2;
    bit          h1, h2, sat, est, ret, acc;
    @(negedge clk);
    ret = wb_we && wb_rd != 0;
    e1 = model_read(rs1_addr);
    e2 = model_read(rs2_addr);
    h1 = issue_use_rs1 && rs1_addr != 0 && mcnt[rs1_addr] > 0 &&
         !(mcnt[rs1_addr] == 1 && ret && wb_rd == rs1_addr);
    h2 = issue_use_rs2 && rs2_addr != 0 && mcnt[rs2_addr] > 0 &&
         !(mcnt[rs2_addr] == 1 && ret && wb_rd == rs2_addr);
    sat = issue_wr && issue_rd != 0 && mcnt[issue_rd] == MaxPending &&
          !(ret && wb_rd == issue_rd);
    est = issue_valid && (h1 || h2 || sat);
    acc = issue_valid && !est && issue_wr && issue_rd != 0;
    if (use_tab) begin
      e1 = t1;
      e2 = t2;
      est = tst;
    end
    check32({name, ".rs1_data"}, rs1_data, e1);
    check32({name, ".rs2_data"}, rs2_data, e2);
    check32({name, ".stall"}, {31'd0, stall}, {31'd0, est});
    // Model update uses the model's own decision, independent of table constants.
    acc = issue_valid && !(issue_valid && (h1 || h2 || sat)) && issue_wr && issue_rd != 0;
    @(posedge clk);
    #1;
    if (ret) mreg[wb_rd] = wb_data;
    if (acc && ret && issue_rd == wb_rd) begin
      // same-register accept and retire cancel
    end else begin
      if (acc) mcnt[issue_rd] = mcnt[issue_rd] + 1;
      if (ret && mcnt[wb_rd] > 0) mcnt[wb_rd] = mcnt[wb_rd] - 1;
    end
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_rd = 0; wb_data = 0; rs1_addr = 0; rs2_addr = 0;
    issue_valid = 0; issue_rd = 0; issue_wr = 0; issue_use_rs1 = 0; issue_use_rs2 = 0;
  endtask

  task automatic add(input bit we, input logic [4:0] rd, input logic [31:0] data,
                     input logic [4:0] a1, input logic [4:0] a2, input bit iv,
                     input logic [4:0] ird, input bit iwr, input bit u1, input bit u2,
                     input logic [31:0] e1, input logic [31:0] e2, input bit est);
    vec_t v;
    v.we = we; v.rd = rd; v.data = data; v.a1 = a1; v.a2 = a2; v.iv = iv; v.ird = ird;
    v.iwr = iwr; v.u1 = u1; v.u2 = u2; v.e1 = e1; v.e2 = e2; v.est = est;
    vecs.push_back(v);
  endtask

  initial begin
    //  we rd  data          a1  a2  iv ird iwr u1 u2  exp rs1       exp rs2       stall
    add(0, 0,  32'h0,        1,  31, 0, 0,  0,  0, 0,  32'h0,        32'h0,        0); // reset
    add(1, 5,  32'hDEADBEEF, 5,  0,  0, 0,  0,  0, 0,  32'hDEADBEEF, 32'h0,        0); // bypass
    add(0, 0,  32'h0,        0,  5,  0, 0,  0,  0, 0,  32'h0,        32'hDEADBEEF, 0); // stored
    add(1, 0,  32'h12345678, 0,  0,  1, 0,  0,  1, 0,  32'h0,        32'h0,        0); // x0 write
    add(0, 0,  32'h0,        5,  0,  1, 7,  1,  0, 0,  32'hDEADBEEF, 32'h0,        0); // issue x7
    add(0, 0,  32'h0,        7,  0,  1, 0,  0,  1, 0,  32'h0,        32'h0,        1); // raw x7
    add(1, 7,  32'hA5,       7,  0,  1, 0,  0,  1, 0,  32'hA5,       32'h0,        0); // retire
    add(0, 0,  32'h0,        7,  0,  1, 3,  1,  0, 0,  32'hA5,       32'h0,        0); // x3 #1
    add(0, 0,  32'h0,        0,  0,  1, 3,  1,  0, 0,  32'h0,        32'h0,        0); // x3 #2
    add(0, 0,  32'h0,        0,  0,  1, 3,  1,  0, 0,  32'h0,        32'h0,        0); // x3 #3
    add(0, 0,  32'h0,        0,  0,  1, 3,  1,  0, 0,  32'h0,        32'h0,        1); // sat
    add(1, 3,  32'h33,       0,  3,  1, 3,  1,  0, 0,  32'h0,        32'h33,       0); // sat+ret
    add(0, 0,  32'h0,        0,  3,  1, 3,  1,  0, 0,  32'h0,        32'h33,       1); // still 3
    add(1, 3,  32'h44,       3,  0,  1, 0,  0,  1, 0,  32'h44,       32'h0,        1); // cnt>1
    add(0, 0,  32'h0,        3,  0,  0, 0,  0,  1, 0,  32'h44,       32'h0,        0); // no valid

    idle_inputs();
    model_clear();
    reset = 1'b1;
    rs1_addr = 5'd1;
    rs2_addr = 5'd31;
    #11;
    check32("in_reset.rs1_data", rs1_data, 32'h0);
    check32("in_reset.stall", {31'd0, stall}, 32'h0);
    #1;
    reset = 1'b0;

    foreach (vecs[k]) begin
      wb_we = vecs[k].we; wb_rd = vecs[k].rd; wb_data = vecs[k].data;
      rs1_addr = vecs[k].a1; rs2_addr = vecs[k].a2;
      issue_valid = vecs[k].iv; issue_rd = vecs[k].ird; issue_wr = vecs[k].iwr;
      issue_use_rs1 = vecs[k].u1; issue_use_rs2 = vecs[k].u2;
      run_cycle($sformatf("vec%0d", k), 1'b1, vecs[k].e1, vecs[k].e2, vecs[k].est);
    end

    // Random traffic on a small register window so collisions and saturation are common.
    for (int n = 0; n < 400; n++) begin
      wb_we = ($urandom_range(0, 99) < 40);
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      issue_valid = ($urandom_range(0, 99) < 75);
      issue_rd = 5'($urandom_range(0, 7));
      issue_wr = ($urandom_range(0, 99) < 70);
      issue_use_rs1 = $urandom_range(0, 1);
      issue_use_rs2 = $urandom_range(0, 1);
      run_cycle($sformatf("rnd%0d", n), 1'b0, '0, '0, 1'b0);
    end

    // Drain every pending write so the reset sequence starts from a known scoreboard.
    idle_inputs();
    for (int r = 1; r < 8; r++) begin
      for (int k = 0; k < MaxPending; k++) begin
        wb_we = 1; wb_rd = 5'(r); wb_data = 32'h100 + 32'(r);
        run_cycle("drain", 1'b0, '0, '0, 1'b0);
      end
    end

    // Mid-cycle asynchronous reset with x9 written and pending.
    idle_inputs();
    wb_we = 1; wb_rd = 5'd9; wb_data = 32'h99;
    run_cycle("wr9", 1'b0, '0, '0, 1'b0);
    idle_inputs();
    issue_valid = 1; issue_rd = 5'd9; issue_wr = 1;
    run_cycle("issue9", 1'b0, '0, '0, 1'b0);
    idle_inputs();
    issue_valid = 1; issue_use_rs1 = 1; rs1_addr = 5'd9; rs2_addr = 5'd9;
    #1;
    check32("pre_reset.stall", {31'd0, stall}, 32'h1);
    check32("pre_reset.rs1_data", rs1_data, 32'h99);
    reset = 1'b1;
    #1;
    check32("async_reset.rs1_data", rs1_data, 32'h0);
    check32("async_reset.rs2_data", rs2_data, 32'h0);
    check32("async_reset.stall", {31'd0, stall}, 32'h0);
    model_clear();
    #2;
    reset = 1'b0;
    run_cycle("post_reset", 1'b0, '0, '0, 1'b0);
    check32("post_reset.model_cnt9", 32'(mcnt[9]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
